// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder: turns validated PS/2 scan-code set 2 bytes into key events.
//   Parses E0 (extended) and F0 (break) prefixes, drops typematic repeats of the
//   held key, maps make/break codes to ASCII, counts presses and queues events in
//   a show-ahead FIFO with a valid/ready handshake.
// Ports:
//   clk, reset                 single clock, synchronous active-high reset
//   rx_valid, rx_data          one-cycle byte strobe from the PS/2 byte receiver
//   ev_valid, ev_ready         event handshake (pop on ev_valid & ev_ready)
//   ev_code/ev_ext/ev_release/ev_ascii   head event fields (zero while empty)
//   key_down, cur_code         currently held key (single-key tracking)
//   press_count                non-repeat make events, modulo 256
//   overflow                   sticky: an event was dropped on a full FIFO
module ps2_key_decoder #(
  parameter int unsigned DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic       ev_valid,
  input  logic       ev_ready,
  output logic [7:0] ev_code,
  output logic       ev_ext,
  output logic       ev_release,
  output logic [7:0] ev_ascii,
  output logic       key_down,
  output logic [7:0] cur_code,
  output logic [7:0] press_count,
  output logic       overflow
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;
  localparam logic [CntW-1:0] FullCount = CntW'(DEPTH);

  // ---------------------------------------------------------------------------
  // Prefix parser
  // ---------------------------------------------------------------------------
  typedef enum logic [1:0] {StIdle, StE0, StF0, StE0F0} state_e;

  state_e state_q, state_d;
  logic   ev_fire;     // final byte of a sequence arrived this cycle
  logic   ev_ext_n;
  logic   ev_rel_n;
  logic   is_e0, is_f0;

  assign is_e0 = (rx_data == 8'hE0);
  assign is_f0 = (rx_data == 8'hF0);

  always_comb begin
    state_d  = state_q;
    ev_fire  = 1'b0;
    ev_ext_n = 1'b0;
    ev_rel_n = 1'b0;
    if (rx_valid) begin
      unique case (state_q)
        StIdle: begin
          if (is_e0)      state_d = StE0;
          else if (is_f0) state_d = StF0;
          else            ev_fire = 1'b1;
        end
        StE0: begin
          if (is_f0)      state_d = StE0F0;
          else if (!is_e0) begin
            ev_fire  = 1'b1;
            ev_ext_n = 1'b1;
            state_d  = StIdle;
          end
        end
        StF0: begin
          // E0 after F0 restarts as an extended sequence; the F0 is discarded.
          if (is_e0)      state_d = StE0;
          else if (!is_f0) begin
            ev_fire  = 1'b1;
            ev_rel_n = 1'b1;
            state_d  = StIdle;
          end
        end
        StE0F0: begin
          if (is_e0)      state_d = StE0;
          else if (is_f0) state_d = StF0;
          else begin
            ev_fire  = 1'b1;
            ev_ext_n = 1'b1;
            ev_rel_n = 1'b1;
            state_d  = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  // ---------------------------------------------------------------------------
  // Held-key tracker and press counter
  // ---------------------------------------------------------------------------
  logic       held_valid;
  logic [7:0] held_code;
  logic       held_ext;
  logic       held_match;
  logic       is_repeat;
  logic       push;

  assign held_match = held_valid && (held_code == rx_data) && (held_ext == ev_ext_n);
  assign is_repeat  = ev_fire && !ev_rel_n && held_match;
  assign push       = ev_fire && !is_repeat;

  always_ff @(posedge clk) begin
    if (reset) begin
      held_valid  <= 1'b0;
      held_code   <= 8'h00;
      held_ext    <= 1'b0;
      press_count <= 8'h00;
    end else if (ev_fire) begin
      // Tracker state follows the key stream even if the FIFO drops the event.
      if (!ev_rel_n && !held_match) begin
        held_valid  <= 1'b1;
        held_code   <= rx_data;
        held_ext    <= ev_ext_n;
        press_count <= press_count + 8'd1;
      end else if (ev_rel_n && held_match) begin
        held_valid <= 1'b0;
      end
    end
  end

  assign key_down = held_valid;
  assign cur_code = held_valid ? held_code : 8'h00;

  // ---------------------------------------------------------------------------
  // Scan code set 2 to ASCII
  // ---------------------------------------------------------------------------
  logic [7:0] map_ascii;
  logic [7:0] push_ascii;

  always_comb begin
    map_ascii = 8'h00;
    case (rx_data)
      8'h1C: map_ascii = 8'h61;  8'h32: map_ascii = 8'h62;  8'h21: map_ascii = 8'h63;
      8'h23: map_ascii = 8'h64;  8'h24: map_ascii = 8'h65;  8'h2B: map_ascii = 8'h66;
      8'h34: map_ascii = 8'h67;  8'h33: map_ascii = 8'h68;  8'h43: map_ascii = 8'h69;
      8'h3B: map_ascii = 8'h6A;  8'h42: map_ascii = 8'h6B;  8'h4B: map_ascii = 8'h6C;
      8'h3A: map_ascii = 8'h6D;  8'h31: map_ascii = 8'h6E;  8'h44: map_ascii = 8'h6F;
      8'h4D: map_ascii = 8'h70;  8'h15: map_ascii = 8'h71;  8'h2D: map_ascii = 8'h72;
      8'h1B: map_ascii = 8'h73;  8'h2C: map_ascii = 8'h74;  8'h3C: map_ascii = 8'h75;
      8'h2A: map_ascii = 8'h76;  8'h1D: map_ascii = 8'h77;  8'h22: map_ascii = 8'h78;
      8'h35: map_ascii = 8'h79;  8'h1A: map_ascii = 8'h7A;
      8'h45: map_ascii = 8'h30;  8'h16: map_ascii = 8'h31;  8'h1E: map_ascii = 8'h32;
      8'h26: map_ascii = 8'h33;  8'h25: map_ascii = 8'h34;  8'h2E: map_ascii = 8'h35;
      8'h36: map_ascii = 8'h36;  8'h3D: map_ascii = 8'h37;  8'h3E: map_ascii = 8'h38;
      8'h46: map_ascii = 8'h39;
      8'h29: map_ascii = 8'h20;
      8'h5A: map_ascii = 8'h0D;
      default: map_ascii = 8'h00;
    endcase
  end

  assign push_ascii = ev_ext_n ? 8'h00 : map_ascii;

  // ---------------------------------------------------------------------------
  // Event FIFO (show-ahead), entry = {code, ext, release, ascii}
  // ---------------------------------------------------------------------------
  logic [17:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            full;
  logic            do_pop;
  logic            do_push;
  logic [17:0]     head;

  assign full     = (count_q == FullCount);
  assign ev_valid = (count_q != '0);
  assign do_pop   = ev_valid && ev_ready;
  // A pop in the same cycle frees the slot the push needs.
  assign do_push  = push && (!full || do_pop);

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= {rx_data, ev_ext_n, ev_rel_n, push_ascii};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      overflow <= 1'b0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 1'b1;
        2'b01:   count_q <= count_q - 1'b1;
        default: count_q <= count_q;
      endcase
      if (push && !do_push) overflow <= 1'b1;
    end
  end

  // Gate with ev_valid so the outputs read zero after reset and while empty.
  assign head = ev_valid ? mem_q[rd_ptr_q] : 18'h0;
  assign {ev_code, ev_ext, ev_release, ev_ascii} = head;

endmodule
